// File: rtl/cp0_regs_if.sv
// Bundle of every cp0_regs signal except clock and reset. The pipeline or
// bench side uses the master modport; the register file uses the slave modport.
interface cp0_regs_if #(
  parameter int IDX_W = 4
);
  logic [5:0]       ext_int_in;
  logic             mtc0_we;
  logic [7:0]       cp0_addr;
  logic [31:0]      cp0_wdata;
  logic [31:0]      cp0_rdata;
  logic             wb_ex;
  logic [4:0]       wb_exccode;
  logic             wb_bd;
  logic [31:0]      wb_pc;
  logic [31:0]      wb_badvaddr;
  logic             wb_tlb_refill;
  logic             eret_flush;
  logic             tlbp_we;
  logic             tlbp_found;
  logic [IDX_W-1:0] tlbp_index;
  logic             tlbr_we;
  logic [77:0]      tlbr_entry;
  logic [IDX_W-1:0] tlb_index;
  logic [77:0]      tlbw_entry;
  logic [26:0]      cp0_entryhi_bus;
  logic [31:0]      cp0_epc;
  logic [31:0]      ex_entry;
  logic             has_int;

  modport master (
    output ext_int_in, mtc0_we, cp0_addr, cp0_wdata, wb_ex, wb_exccode, wb_bd,
           wb_pc, wb_badvaddr, wb_tlb_refill, eret_flush, tlbp_we, tlbp_found,
           tlbp_index, tlbr_we, tlbr_entry,
    input  cp0_rdata, tlb_index, tlbw_entry, cp0_entryhi_bus, cp0_epc,
           ex_entry, has_int
  );

  modport slave (
    input  ext_int_in, mtc0_we, cp0_addr, cp0_wdata, wb_ex, wb_exccode, wb_bd,
           wb_pc, wb_badvaddr, wb_tlb_refill, eret_flush, tlbp_we, tlbp_found,
           tlbp_index, tlbr_we, tlbr_entry,
    output cp0_rdata, tlb_index, tlbw_entry, cp0_entryhi_bus, cp0_epc,
           ex_entry, has_int
  );
endinterface

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS-style coprocessor-0 register file (Index, EntryLo0/1,
// BadVAddr, Count, EntryHi, Compare, Status, Cause, EPC) with exception,
// ERET, TLBP/TLBR and timer-interrupt handling.
module cp0_regs #(
  parameter int TLBNUM    = 16,
  parameter int IDX_W     = $clog2(TLBNUM),
  parameter int COUNT_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  cp0_regs_if.slave  bus
);
  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  localparam logic [7:0] A_INDEX = 8'h00, A_LO0 = 8'h10, A_LO1 = 8'h18,
                         A_BADV  = 8'h40, A_COUNT = 8'h48, A_HI = 8'h50,
                         A_CMP   = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68,
                         A_EPC   = 8'h70;

  // Architectural state, one field per register field
  logic             idx_p;
  logic [IDX_W-1:0] idx;
  logic [24:0]      lo0, lo1;       // {PFN, C, D, V}
  logic             g0, g1;
  logic [18:0]      vpn2;
  logic [7:0]       asid;
  logic [31:0]      badvaddr, count, compare, epc;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       im;
  logic             exl, ie;
  logic             bd, ti;
  logic [7:0]       ip;
  logic [4:0]       exccode;

  // Strobe arbitration: a higher-priority event suppresses all lower ones
  logic eret_go, tlb_go, mtc0_go;
  assign eret_go = bus.eret_flush & ~bus.wb_ex;
  assign tlb_go  = (bus.tlbr_we | bus.tlbp_we) & ~bus.wb_ex & ~bus.eret_flush;
  assign mtc0_go = bus.mtc0_we & ~bus.wb_ex & ~bus.eret_flush & ~bus.tlbr_we & ~bus.tlbp_we;

  logic wr_index, wr_lo0, wr_lo1, wr_count, wr_hi, wr_cmp, wr_status, wr_cause, wr_epc;
  assign wr_index  = mtc0_go && (bus.cp0_addr == A_INDEX);
  assign wr_lo0    = mtc0_go && (bus.cp0_addr == A_LO0);
  assign wr_lo1    = mtc0_go && (bus.cp0_addr == A_LO1);
  assign wr_count  = mtc0_go && (bus.cp0_addr == A_COUNT);
  assign wr_hi     = mtc0_go && (bus.cp0_addr == A_HI);
  assign wr_cmp    = mtc0_go && (bus.cp0_addr == A_CMP);
  assign wr_status = mtc0_go && (bus.cp0_addr == A_STATUS);
  assign wr_cause  = mtc0_go && (bus.cp0_addr == A_CAUSE);
  assign wr_epc    = mtc0_go && (bus.cp0_addr == A_EPC);

  // Address-type exceptions record BadVAddr; TLB ones also record VPN2
  logic code_badv, code_tlb;
  assign code_badv = (bus.wb_exccode >= 5'd1) && (bus.wb_exccode <= 5'd5);
  assign code_tlb  = (bus.wb_exccode >= 5'd1) && (bus.wb_exccode <= 5'd3);

  // Status, EPC, BadVAddr: exception entry / ERET / MTC0
  always_ff @(posedge clk) begin
    if (reset) begin
      im <= '0; exl <= 1'b0; ie <= 1'b0; epc <= '0; badvaddr <= '0;
    end else if (bus.wb_ex) begin
      exl <= 1'b1;
      if (!exl) epc <= bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
      if (code_badv) badvaddr <= bus.wb_badvaddr;
    end else if (eret_go) begin
      exl <= 1'b0;
    end else if (wr_status) begin
      im  <= bus.cp0_wdata[15:8];
      exl <= bus.cp0_wdata[1];
      ie  <= bus.cp0_wdata[0];
    end else if (wr_epc) begin
      epc <= bus.cp0_wdata;
    end
  end

  // Cause: interrupt sampling every cycle, timer flag, exception fields
  always_ff @(posedge clk) begin
    if (reset) begin
      bd <= 1'b0; ti <= 1'b0; ip <= '0; exccode <= '0;
    end else begin
      ip[7]   <= bus.ext_int_in[5] | ti;
      ip[6:2] <= bus.ext_int_in[4:0];
      if (wr_cmp) ti <= 1'b0;
      else if (count == compare) ti <= 1'b1;
      if (bus.wb_ex) begin
        exccode <= bus.wb_exccode;
        if (!exl) bd <= bus.wb_bd;
      end else if (wr_cause) begin
        ip[1:0] <= bus.cp0_wdata[9:8];
      end
    end
  end

  // Count with clock divider, and Compare
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0; div_cnt <= '0; compare <= 32'hFFFF_FFFF;
    end else begin
      if (wr_count) begin
        count   <= bus.cp0_wdata;
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        count   <= count + 32'd1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (wr_cmp) compare <= bus.cp0_wdata;
    end
  end

  // TLB-facing registers: Index, EntryHi, EntryLo0/1
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_p <= 1'b0; idx <= '0; vpn2 <= '0; asid <= '0;
      lo0 <= '0; lo1 <= '0; g0 <= 1'b0; g1 <= 1'b0;
    end else if (bus.wb_ex) begin
      if (code_tlb) vpn2 <= bus.wb_badvaddr[31:13];
    end else if (eret_go) begin
      idx_p <= idx_p;
    end else if (tlb_go) begin
      if (bus.tlbp_we) begin
        idx_p <= ~bus.tlbp_found;
        if (bus.tlbp_found) idx <= bus.tlbp_index;
      end
      if (bus.tlbr_we) begin
        vpn2 <= bus.tlbr_entry[77:59];
        asid <= bus.tlbr_entry[58:51];
        g0   <= bus.tlbr_entry[50];
        g1   <= bus.tlbr_entry[50];
        lo0  <= bus.tlbr_entry[49:25];
        lo1  <= bus.tlbr_entry[24:0];
      end
    end else begin
      if (wr_index) idx <= bus.cp0_wdata[IDX_W-1:0];
      if (wr_hi) begin
        vpn2 <= bus.cp0_wdata[31:13];
        asid <= bus.cp0_wdata[7:0];
      end
      if (wr_lo0) begin
        lo0 <= bus.cp0_wdata[25:1];
        g0  <= bus.cp0_wdata[0];
      end
      if (wr_lo1) begin
        lo1 <= bus.cp0_wdata[25:1];
        g1  <= bus.cp0_wdata[0];
      end
    end
  end

  // Combinational read mux; unmapped addresses read zero
  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      A_INDEX:  bus.cp0_rdata = {idx_p, {(31-IDX_W){1'b0}}, idx};
      A_LO0:    bus.cp0_rdata = {6'b0, lo0, g0};
      A_LO1:    bus.cp0_rdata = {6'b0, lo1, g1};
      A_BADV:   bus.cp0_rdata = badvaddr;
      A_COUNT:  bus.cp0_rdata = count;
      A_HI:     bus.cp0_rdata = {vpn2, 5'b0, asid};
      A_CMP:    bus.cp0_rdata = compare;
      A_STATUS: bus.cp0_rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      A_CAUSE:  bus.cp0_rdata = {bd, ti, 14'b0, ip, 1'b0, exccode, 2'b0};
      A_EPC:    bus.cp0_rdata = epc;
      default:  bus.cp0_rdata = '0;
    endcase
  end

  assign bus.tlb_index       = idx;
  assign bus.tlbw_entry      = {vpn2, asid, g0 & g1, lo0, lo1};
  assign bus.cp0_entryhi_bus = {vpn2, asid};
  assign bus.cp0_epc         = epc;
  assign bus.ex_entry        = (bus.wb_tlb_refill && !exl) ? 32'hBFC0_0200 : 32'hBFC0_0380;
  assign bus.has_int         = (|(ip & im)) & ie & ~exl;
endmodule

// File: tb/tb_cp0_regs.sv
// Testbench for cp0_regs: directed scenarios plus randomized strobes, all
// compared against a word-level architectural model of the CP0 registers.
module tb_cp0_regs;
  localparam int TLBNUM = 32;
  localparam int IDX_W = 5;
  localparam int COUNT_DIV = 2;
  localparam logic [31:0] IDX_MASK = 32'(TLBNUM - 1);
  localparam logic [7:0] RD_ADDRS [12] = '{8'h00, 8'h10, 8'h18, 8'h40, 8'h48, 8'h50,
                                           8'h58, 8'h60, 8'h68, 8'h70, 8'h08, 8'h61};

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  cp0_regs_if #(.IDX_W(IDX_W)) bus ();
  cp0_regs #(.TLBNUM(TLBNUM), .IDX_W(IDX_W), .COUNT_DIV(COUNT_DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Model state: full 32-bit architectural register words
  logic [31:0] m_index = 0, m_lo0 = 0, m_lo1 = 0, m_badv = 0, m_count = 0, m_hi = 0;
  logic [31:0] m_cmp = 0, m_status = 0, m_cause = 0, m_epc = 0;
  int m_div = 0;
  logic [31:0] n_index, n_lo0, n_lo1, n_badv, n_count, n_hi, n_cmp, n_status, n_cause, n_epc;
  int n_div;

  task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_index;
      8'h10: return m_lo0;
      8'h18: return m_lo1;
      8'h40: return m_badv;
      8'h48: return m_count;
      8'h50: return m_hi;
      8'h58: return m_cmp;
      8'h60: return m_status;
      8'h68: return m_cause;
      8'h70: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Next architectural state from current state and the inputs now applied
  task automatic model_step();
    logic [7:0] a;
    logic [31:0] w;
    logic [77:0] e;
    logic [4:0] code;
    logic eret_go, tlb_go, mt;
    n_index = m_index; n_lo0 = m_lo0; n_lo1 = m_lo1; n_badv = m_badv; n_count = m_count;
    n_hi = m_hi; n_cmp = m_cmp; n_status = m_status; n_cause = m_cause; n_epc = m_epc;
    n_div = m_div;
    a = bus.cp0_addr; w = bus.cp0_wdata; e = bus.tlbr_entry; code = bus.wb_exccode;
    eret_go = bus.eret_flush && !bus.wb_ex;
    tlb_go = (bus.tlbr_we || bus.tlbp_we) && !bus.wb_ex && !bus.eret_flush;
    mt = bus.mtc0_we && !bus.wb_ex && !bus.eret_flush && !bus.tlbr_we && !bus.tlbp_we;

    if (mt && a == 8'h48) begin n_count = w; n_div = 0; end
    else if (m_div == COUNT_DIV - 1) begin n_count = m_count + 1; n_div = 0; end
    else n_div = m_div + 1;
    if (mt && a == 8'h58) n_cmp = w;

    if (mt && a == 8'h58) n_cause[30] = 1'b0;
    else if (m_count == m_cmp) n_cause[30] = 1'b1;
    n_cause[15] = bus.ext_int_in[5] | m_cause[30];
    n_cause[14:10] = bus.ext_int_in[4:0];

    if (bus.wb_ex) begin
      if (!m_status[1]) begin
        n_epc = bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
        n_cause[31] = bus.wb_bd;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = code;
      if (code >= 1 && code <= 5) n_badv = bus.wb_badvaddr;
      if (code >= 1 && code <= 3) n_hi = {bus.wb_badvaddr[31:13], m_hi[12:0]};
    end else if (eret_go) begin
      n_status[1] = 1'b0;
    end else if (tlb_go) begin
      if (bus.tlbr_we) begin
        n_hi = {e[77:59], 5'b0, e[58:51]};
        n_lo0 = {6'b0, e[49:25], e[50]};
        n_lo1 = {6'b0, e[24:0], e[50]};
      end
      if (bus.tlbp_we)
        n_index = bus.tlbp_found ? 32'(bus.tlbp_index) : (m_index | 32'h8000_0000);
    end else if (mt) begin
      case (a)
        8'h00: n_index = (m_index & 32'h8000_0000) | (w & IDX_MASK);
        8'h10: n_lo0 = w & 32'h03FF_FFFF;
        8'h18: n_lo1 = w & 32'h03FF_FFFF;
        8'h50: n_hi = w & 32'hFFFF_E0FF;
        8'h60: n_status = (m_status & ~32'h0000_FF03) | (w & 32'h0000_FF03);
        8'h68: n_cause[9:8] = w[9:8];
        8'h70: n_epc = w;
        default: ;
      endcase
    end

    if (reset) begin
      n_index = 0; n_lo0 = 0; n_lo1 = 0; n_badv = 0; n_count = 0; n_div = 0;
      n_hi = 0; n_cmp = 32'hFFFF_FFFF; n_status = 32'h0040_0000; n_cause = 0; n_epc = 0;
    end
  endtask

  task automatic check_all();
    logic [7:0] saved;
    logic hi_exp;
    saved = bus.cp0_addr;
    hi_exp = (|(m_cause[15:8] & m_status[15:8])) & m_status[0] & !m_status[1];
    chk("has_int", bus.has_int, hi_exp);
    chk("ex_entry", bus.ex_entry,
        (bus.wb_tlb_refill && !m_status[1]) ? 32'hBFC0_0200 : 32'hBFC0_0380);
    chk("tlb_index", bus.tlb_index, m_index[IDX_W-1:0]);
    chk("tlbw_entry", bus.tlbw_entry,
        {m_hi[31:13], m_hi[7:0], m_lo0[0] & m_lo1[0], m_lo0[25:1], m_lo1[25:1]});
    chk("entryhi_bus", bus.cp0_entryhi_bus, {m_hi[31:13], m_hi[7:0]});
    chk("epc_out", bus.cp0_epc, m_epc);
    foreach (RD_ADDRS[i]) begin
      bus.cp0_addr = RD_ADDRS[i];
      #1;
      chk($sformatf("rd%02h", RD_ADDRS[i]), bus.cp0_rdata, m_read(RD_ADDRS[i]));
    end
    bus.cp0_addr = saved;
    #1;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    m_index = n_index; m_lo0 = n_lo0; m_lo1 = n_lo1; m_badv = n_badv; m_count = n_count;
    m_hi = n_hi; m_cmp = n_cmp; m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_div = n_div;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    reset = 1'b0;
    bus.ext_int_in = '0; bus.mtc0_we = 1'b0; bus.cp0_addr = '0; bus.cp0_wdata = '0;
    bus.wb_ex = 1'b0; bus.wb_exccode = '0; bus.wb_bd = 1'b0; bus.wb_pc = '0;
    bus.wb_badvaddr = '0; bus.wb_tlb_refill = 1'b0; bus.eret_flush = 1'b0;
    bus.tlbp_we = 1'b0; bus.tlbp_found = 1'b0; bus.tlbp_index = '0;
    bus.tlbr_we = 1'b0; bus.tlbr_entry = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus.cp0_addr = a;
    #1;
    v = bus.cp0_rdata;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] w);
    idle();
    bus.mtc0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = w;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; cycle(); idle();
  endtask

  initial begin
    logic [31:0] v;
    logic [77:0] ent;
    do_reset();

    // Nested exception: EPC/BD captured only on the first
    bus.wb_ex = 1'b1; bus.wb_bd = 1'b1; bus.wb_pc = 32'hBFC0_1004;
    bus.wb_exccode = 5'd4; bus.wb_badvaddr = 32'h1003;
    cycle(); idle();
    rd(8'h70, v); chk("nest_epc", v, 32'hBFC0_1000);
    rd(8'h68, v); chk("nest_bd", v[31], 1'b1);
    rd(8'h40, v); chk("nest_badv", v, 32'h1003);
    rd(8'h60, v); chk("nest_exl", v[1], 1'b1);
    bus.wb_ex = 1'b1; bus.wb_pc = 32'h2000; bus.wb_exccode = 5'd8;
    cycle(); idle();
    rd(8'h70, v); chk("nest_epc2", v, 32'hBFC0_1000);
    rd(8'h68, v); chk("nest_code2", v[6:2], 5'd8);

    // TLB refill vector selection
    do_reset();
    bus.wb_ex = 1'b1; bus.wb_exccode = 5'd2; bus.wb_tlb_refill = 1'b1;
    bus.wb_badvaddr = 32'h0040_3ABC;
    #1; chk("refill_vec", bus.ex_entry, 32'hBFC0_0200);
    cycle();
    rd(8'h50, v); chk("refill_vpn2", v[31:13], 19'h00201);
    #1; chk("refill_vec_exl", bus.ex_entry, 32'hBFC0_0380);
    cycle(); idle();

    // Timer interrupt
    do_reset();
    mtc0(8'h58, 32'd5);
    mtc0(8'h60, 32'h0000_8001);
    mtc0(8'h48, 32'd0);
    repeat (10) cycle();
    rd(8'h48, v); chk("timer_count", v, 32'd5);
    rd(8'h68, v); chk("timer_ti0", v[30], 1'b0);
    cycle();
    rd(8'h68, v); chk("timer_ti1", v[30], 1'b1);
    chk("timer_int0", bus.has_int, 1'b0);
    cycle();
    chk("timer_int1", bus.has_int, 1'b1);
    mtc0(8'h58, 32'd100);
    rd(8'h68, v); chk("timer_ticlr", v[30], 1'b0);

    // TLBP miss / hit and Index write masking
    do_reset();
    mtc0(8'h00, 32'd3);
    bus.tlbp_we = 1'b1; bus.tlbp_found = 1'b0; bus.tlbp_index = 5'd12;
    cycle(); idle();
    rd(8'h00, v); chk("tlbp_miss", v, 32'h8000_0003);
    bus.tlbp_we = 1'b1; bus.tlbp_found = 1'b1; bus.tlbp_index = 5'd9;
    cycle(); idle();
    rd(8'h00, v); chk("tlbp_hit", v, 32'd9);
    mtc0(8'h00, 32'hFFFF_FFFF);
    rd(8'h00, v); chk("index_mask", v, 32'h1F);

    // TLBR then write-port entry
    ent = {$urandom, $urandom, 14'($urandom)};
    ent[50] = 1'b1;
    bus.tlbr_we = 1'b1; bus.tlbr_entry = ent;
    cycle(); idle();
    rd(8'h10, v); chk("tlbr_g0", v[0], 1'b1);
    rd(8'h18, v); chk("tlbr_g1", v[0], 1'b1);
    chk("tlbr_roundtrip", bus.tlbw_entry, ent);

    // Simultaneous strobes
    do_reset();
    bus.wb_ex = 1'b1; bus.eret_flush = 1'b1; bus.wb_exccode = 5'd0;
    cycle(); idle();
    rd(8'h60, v); chk("ex_over_eret", v[1], 1'b1);
    reset = 1'b1; bus.wb_ex = 1'b1; bus.wb_exccode = 5'd2; bus.wb_badvaddr = 32'hDEAD_BEEF;
    bus.wb_pc = 32'h1234; bus.ext_int_in = 6'h3F;
    cycle(); idle();
    rd(8'h00, v); chk("rst_index", v, 32'h0);
    rd(8'h10, v); chk("rst_lo0", v, 32'h0);
    rd(8'h18, v); chk("rst_lo1", v, 32'h0);
    rd(8'h40, v); chk("rst_badv", v, 32'h0);
    rd(8'h48, v); chk("rst_count", v, 32'h0);
    rd(8'h50, v); chk("rst_hi", v, 32'h0);
    rd(8'h58, v); chk("rst_cmp", v, 32'hFFFF_FFFF);
    rd(8'h60, v); chk("rst_status", v, 32'h0040_0000);
    rd(8'h68, v); chk("rst_cause", v, 32'h0);
    rd(8'h70, v); chk("rst_epc", v, 32'h0);
    chk("rst_has_int", bus.has_int, 1'b0);
    chk("rst_ex_entry", bus.ex_entry, 32'hBFC0_0380);

    // Randomized strobes against the model
    for (int i = 0; i < 400; i++) begin
      idle();
      reset = ($urandom_range(0, 149) == 0);
      bus.ext_int_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      bus.mtc0_we = ($urandom_range(0, 2) == 0);
      bus.cp0_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : RD_ADDRS[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0: bus.cp0_wdata = 32'hFFFF_FFFE;
        1: bus.cp0_wdata = 32'($urandom_range(0, 40));
        default: bus.cp0_wdata = $urandom;
      endcase
      bus.wb_ex = ($urandom_range(0, 9) == 0);
      bus.wb_exccode = 5'($urandom_range(0, 12));
      bus.wb_bd = 1'($urandom);
      bus.wb_pc = $urandom;
      bus.wb_badvaddr = $urandom;
      bus.wb_tlb_refill = 1'($urandom);
      bus.eret_flush = ($urandom_range(0, 7) == 0);
      bus.tlbp_we = ($urandom_range(0, 9) == 0);
      bus.tlbp_found = 1'($urandom);
      bus.tlbp_index = 5'($urandom);
      bus.tlbr_we = ($urandom_range(0, 9) == 0);
      bus.tlbr_entry = {$urandom, $urandom, 14'($urandom)};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
